match_event_counter: RTL and testbench

Downstream consumer of the serial sequence detector's match output. Samples the detector's one-cycle `y` pulse every clock, keeps a saturating match count, measures the cycle gap between successive matches, and raises a sticky alert plus a one-cycle interrupt when the count reaches a programmable threshold. All outputs are registered. It sits between the detector and the lab's status/LED logic.

---
 rtl/match_pkg.sv | 6 +
 rtl/gap_timer.sv | 32 +++
 rtl/match_event_counter.sv | 67 ++++++
 tb/tb_match_event_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared FSM state encoding and default widths for match_event_counter
package match_pkg;
  typedef enum logic [1:0] {IDLE, COUNTING, ALERT} state_t;
  localparam int DEF_COUNT_W = 8;
  localparam int DEF_GAP_W = 8;
endpackage

// File: rtl/gap_timer.sv
// gap_timer: saturating match-gap timer (clk, reset, clear, tick, hit -> last_gap, gap_valid); timer==0 means no match seen yet
module gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic             hit,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid
);
  logic [GAP_W-1:0] timer;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer <= '0;
      last_gap <= '0;
      gap_valid <= 1'b0;
    end else if (clear) begin
      timer <= '0;
      last_gap <= '0;
      gap_valid <= 1'b0;
    end else if (hit) begin
      if (timer != '0) begin
        last_gap <= timer;
        gap_valid <= 1'b1;
      end
      timer <= GAP_W'(1);
    end else if (tick && timer != '0 && !(&timer)) begin
      timer <= timer + GAP_W'(1);
    end
endmodule

// File: rtl/match_event_counter.sv
// match_event_counter: counts detector match pulses (y_in, en, clear, thresh -> count, last_gap, gap_valid, alert, irq, overflow)
module match_event_counter
  import match_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               y_in,
  input  logic               en,
  input  logic               clear,
  input  logic [COUNT_W-1:0] thresh,
  output logic [COUNT_W-1:0] count,
  output logic [GAP_W-1:0]   last_gap,
  output logic               gap_valid,
  output logic               alert,
  output logic               irq,
  output logic               overflow
);
  state_t state, state_nxt;
  logic active, hit, sat, fire;
  logic [COUNT_W-1:0] next_count;
  assign active = state != IDLE;
  assign hit = active & en & y_in & ~clear;
  assign sat = &count;
  assign next_count = sat ? count : count + COUNT_W'(1);
  // an already-raised alert (e.g. after an en drop) must not pulse irq again
  assign fire = hit & ~alert & (thresh != '0) & (next_count >= thresh);
  always_comb begin
    state_nxt = state;
    state_nxt = clear ? (en ? COUNTING : IDLE) :
                !en ? IDLE :
                state == IDLE ? COUNTING :
                (fire || state == ALERT) ? ALERT : COUNTING;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      alert <= 1'b0;
      irq <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        count <= '0;
        alert <= 1'b0;
        irq <= 1'b0;
        overflow <= 1'b0;
      end else begin
        irq <= fire;
        if (hit) count <= next_count;
        if (hit && sat) overflow <= 1'b1;
        if (fire) alert <= 1'b1;
      end
    end
  gap_timer #(.GAP_W(GAP_W)) u_gap (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .tick(active & en),
    .hit(hit),
    .last_gap(last_gap),
    .gap_valid(gap_valid)
  );
endmodule

// File: tb/tb_match_event_counter.sv
// tb_match_event_counter: scoreboard bench for match_event_counter
module tb_match_event_counter;
  typedef struct {
    logic [7:0] count;
    logic [7:0] gap;
    logic gv, alert, irq, ovf;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, y_in = 1'b0, en = 1'b0, clear = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic [7:0] count, last_gap;
  logic gap_valid, alert, irq, overflow;
  int errors = 0, checks = 0;
  exp_t q[$];
  int m_state, m_count, m_timer, m_gap;
  logic m_gv, m_alert, m_irq, m_ovf;
  match_event_counter dut (
    .clk(clk), .reset(reset), .y_in(y_in), .en(en), .clear(clear), .thresh(thresh),
    .count(count), .last_gap(last_gap), .gap_valid(gap_valid),
    .alert(alert), .irq(irq), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (count !== e.count || last_gap !== e.gap || gap_valid !== e.gv ||
          alert !== e.alert || irq !== e.irq || overflow !== e.ovf) begin
        errors++;
        $display("FAIL sb t=%0t got cnt=%0d gap=%0d gv=%b al=%b irq=%b ov=%b exp cnt=%0d gap=%0d gv=%b al=%b irq=%b ov=%b",
          $time, count, last_gap, gap_valid, alert, irq, overflow,
          e.count, e.gap, e.gv, e.alert, e.irq, e.ovf);
      end
    end
  end
  task automatic model_reset();
    m_state = 0; m_count = 0; m_timer = 0; m_gap = 0;
    m_gv = 0; m_alert = 0; m_irq = 0; m_ovf = 0;
  endtask
  task automatic drive(input logic y, input logic e, input logic c);
    bit act, hit;
    exp_t x;
    @(negedge clk);
    y_in = y; en = e; clear = c;
    act = m_state != 0;
    if (c) begin
      m_count = 0; m_timer = 0; m_gap = 0;
      m_gv = 0; m_alert = 0; m_irq = 0; m_ovf = 0;
      m_state = e ? 1 : 0;
    end else begin
      hit = act && e && y;
      m_irq = 0;
      if (hit) begin
        if (m_count == 255) m_ovf = 1; else m_count++;
        if (m_timer > 0) begin m_gap = m_timer; m_gv = 1; end
        m_timer = 1;
        if (!m_alert && thresh != 0 && m_count >= int'(thresh)) begin
          m_alert = 1; m_irq = 1;
        end
      end else if (act && e && m_timer > 0) begin
        m_timer = (m_timer >= 255) ? 255 : m_timer + 1;
      end
      m_state = !e ? 0 : (m_state == 0 ? 1 : ((m_irq || m_state == 2) ? 2 : 1));
    end
    x.count = 8'(m_count); x.gap = 8'(m_gap);
    x.gv = m_gv; x.alert = m_alert; x.irq = m_irq; x.ovf = m_ovf;
    q.push_back(x);
  endtask
  task automatic settle();
    @(posedge clk); #2;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({count, last_gap, gap_valid, alert, irq, overflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d gap=%0d gv=%b al=%b irq=%b ov=%b want all 0",
        count, last_gap, gap_valid, alert, irq, overflow);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask
  task automatic test_basic();
    thresh = 8'd3;
    for (int c = 1; c <= 25; c++) drive(c == 10 || c == 13 || c == 20 || c == 23, 1'b1, 1'b0);
    settle();
    checks++;
    if (count !== 8'd4 || last_gap !== 8'd3 || alert !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_final got cnt=%0d gap=%0d al=%b irq=%b want 4 3 1 0", count, last_gap, alert, irq);
    end
  endtask
  task automatic test_thresh_zero();
    drive(0, 1, 1);
    thresh = 8'd0;
    for (int i = 0; i < 10; i++) drive(i % 2 == 0, 1'b1, 1'b0);
    settle();
    checks++;
    if (count !== 8'd5 || alert !== 1'b0) begin
      errors++;
      $display("FAIL thresh_zero got cnt=%0d al=%b want 5 0", count, alert);
    end
  endtask
  task automatic test_saturate();
    drive(0, 1, 1);
    for (int i = 0; i < 256; i++) drive(1, 1, 0);
    drive(0, 1, 0);
    settle();
    checks++;
    if (count !== 8'd255 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturate got cnt=%0d ov=%b want 255 1", count, overflow);
    end
  endtask
  task automatic test_long_gap();
    drive(0, 1, 1);
    drive(1, 1, 0);
    for (int i = 0; i < 299; i++) drive(0, 1, 0);
    drive(1, 1, 0);
    settle();
    checks++;
    if (last_gap !== 8'd255 || gap_valid !== 1'b1) begin
      errors++;
      $display("FAIL long_gap got gap=%0d gv=%b want 255 1", last_gap, gap_valid);
    end
  endtask
  task automatic test_en_window();
    drive(0, 1, 1);
    drive(1, 1, 0); drive(0, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
    drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
    settle();
    checks++;
    if (count !== 8'd2 || last_gap !== 8'd3) begin
      errors++;
      $display("FAIL en_window got cnt=%0d gap=%0d want 2 3", count, last_gap);
    end
    drive(0, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
    settle();
    checks++;
    if (count !== 8'd3 || last_gap !== 8'd2) begin
      errors++;
      $display("FAIL en_resume got cnt=%0d gap=%0d want 3 2", count, last_gap);
    end
  endtask
  task automatic test_clear_in_alert();
    drive(0, 1, 1);
    thresh = 8'd1;
    drive(1, 1, 0); drive(0, 1, 0);
    drive(1, 1, 1);
    settle();
    checks++;
    if ({count, last_gap, gap_valid, alert, irq, overflow} !== 20'd0) begin
      errors++;
      $display("FAIL clear_alert got cnt=%0d gap=%0d gv=%b al=%b irq=%b ov=%b want all 0",
        count, last_gap, gap_valid, alert, irq, overflow);
    end
    drive(1, 1, 0);
    settle();
    checks++;
    if (count !== 8'd1 || irq !== 1'b1 || alert !== 1'b1) begin
      errors++;
      $display("FAIL clear_counting got cnt=%0d irq=%b al=%b want 1 1 1", count, irq, alert);
    end
  endtask
  task automatic test_async_reset();
    drive(0, 1, 1);
    thresh = 8'd2;
    drive(1, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
    settle();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({count, last_gap, gap_valid, alert, irq, overflow} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d gap=%0d gv=%b al=%b irq=%b ov=%b want all 0",
        count, last_gap, gap_valid, alert, irq, overflow);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    en = 1'b0; y_in = 1'b0; clear = 1'b0;
    model_reset();
    drive(0, 1, 0); drive(1, 1, 0);
    settle();
  endtask
  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_thresh_zero();
    test_saturate();
    test_long_gap();
    test_en_window();
    test_clear_in_alert();
    test_async_reset();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
